// File: rtl/n64_pkg.sv
// Shared constants, response buffer type and sequencer state encoding for the
// N64 response path.
package n64_pkg;

  localparam int RESP_MAX_BYTES = 4;

  localparam logic [7:0] CMD_IDENTITY = 8'h00;
  localparam logic [7:0] CMD_STATUS   = 8'h01;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] ID_BYTE0 = 8'h05;
  localparam logic [7:0] ID_BYTE1 = 8'h00;
  localparam logic [7:0] ID_BYTE2 = 8'h02;

  // Element 0 is transmitted first.
  typedef logic [RESP_MAX_BYTES-1:0][7:0] resp_buf_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TURN,
    ST_LOAD,
    ST_PULSE,
    ST_SETTLE,
    ST_WAIT,
    ST_STOP_PULSE,
    ST_STOP_SETTLE,
    ST_STOP_WAIT
  } state_t;

endpackage

// File: rtl/n64_resp_rom.sv
// Combinational command decode: maps a command code plus live controller state
// to the response length, the response bytes and a supported flag.
module n64_resp_rom
  import n64_pkg::*;
(
  input  logic [7:0]  cmd_byte,
  input  logic [15:0] buttons,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  output logic [2:0]  len,
  output resp_buf_t   resp,
  output logic        supported
);

  always_comb begin
    len       = 3'd0;
    resp      = '0;
    supported = 1'b0;
    case (cmd_byte)
      CMD_IDENTITY, CMD_RESET: begin
        len       = 3'd3;
        resp[0]   = ID_BYTE0;
        resp[1]   = ID_BYTE1;
        resp[2]   = ID_BYTE2;
        supported = 1'b1;
      end
      CMD_STATUS: begin
        len       = 3'd4;
        resp[0]   = buttons[15:8];
        resp[1]   = buttons[7:0];
        resp[2]   = joy_x;
        resp[3]   = joy_y;
        supported = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/n64_response_sequencer.sv
// Response sequencer: turnaround gap, byte-by-byte transmit, stop bit.
// Optional transmitter watchdog enabled by defining N64_TX_WATCHDOG_EN.
//
// state       | meaning
// IDLE        | waiting for a command
// TURN        | turnaround gap before the first byte
// LOAD        | present buf[idx] on tx_byte
// PULSE       | byte transmitter start pulse
// SETTLE      | blanking cycle while tx_byte_busy rises
// WAIT        | waiting for the byte transmitter to finish
// STOP_PULSE  | stop-bit transmitter start pulse, line owned by stop tx
// STOP_SETTLE | blanking cycle while tx_stop_busy rises
// STOP_WAIT   | waiting for the stop-bit transmitter to finish
module n64_response_sequencer
  import n64_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 100,
  parameter int WDOG_CYCLES       = 4096
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic [15:0] buttons,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_trigger,
  input  logic        tx_byte_busy,
  output logic        tx_stop_trigger,
  input  logic        tx_stop_busy,
  output logic        tx_sel,
  output logic        busy,
  output logic        cmd_dropped,
  output logic        cmd_unsupported,
  output logic        tx_error
);

`ifdef N64_TX_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam int TURN_W = $clog2(TURNAROUND_CYCLES + 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND_CYCLES - 1);
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  resp_buf_t         resp_q, resp_d;
  logic [2:0]        len_q, len_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              dropped_q, dropped_d;
  logic              unsup_q, unsup_d;
  logic              err_q, err_d;

  logic [2:0]        rom_len;
  resp_buf_t         rom_resp;
  logic              rom_supported;
  logic              last_byte;
  logic              waiting;
  logic              wdog_hit;

  n64_resp_rom u_rom (
    .cmd_byte  (cmd_byte),
    .buttons   (buttons),
    .joy_x     (joy_x),
    .joy_y     (joy_y),
    .len       (rom_len),
    .resp      (rom_resp),
    .supported (rom_supported)
  );

  assign last_byte = ({1'b0, idx_q} == (len_q - 3'd1));
  assign waiting   = (state_q == ST_WAIT) || (state_q == ST_STOP_WAIT);
  assign wdog_hit  = WDOG_EN && (wdog_q == WDOG_LAST) &&
                     (((state_q == ST_WAIT) && tx_byte_busy) ||
                      ((state_q == ST_STOP_WAIT) && tx_stop_busy));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      turn_q    <= '0;
      wdog_q    <= '0;
      resp_q    <= '0;
      len_q     <= '0;
      tx_byte_q <= '0;
      dropped_q <= 1'b0;
      unsup_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      turn_q    <= turn_d;
      wdog_q    <= wdog_d;
      resp_q    <= resp_d;
      len_q     <= len_d;
      tx_byte_q <= tx_byte_d;
      dropped_q <= dropped_d;
      unsup_q   <= unsup_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    turn_d    = turn_q;
    resp_d    = resp_q;
    len_d     = len_q;
    tx_byte_d = tx_byte_q;
    unsup_d   = 1'b0;
    err_d     = 1'b0;
    dropped_d = cmd_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (rom_supported) begin
            resp_d  = rom_resp;
            len_d   = rom_len;
            idx_d   = 2'd0;
            turn_d  = TURN_LOAD;
            state_d = ST_TURN;
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      ST_TURN: begin
        if (turn_q == '0) begin
          tx_byte_d = resp_q[idx_q];
          state_d   = ST_LOAD;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end
      ST_LOAD:   state_d = ST_PULSE;
      ST_PULSE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!tx_byte_busy) begin
          if (last_byte) begin
            state_d = ST_STOP_PULSE;
          end else begin
            // tx_byte changes on LOAD entry so it is stable through PULSE.
            idx_d     = idx_q + 2'd1;
            tx_byte_d = resp_q[idx_q + 2'd1];
            state_d   = ST_LOAD;
          end
        end
      end
      ST_STOP_PULSE:  state_d = ST_STOP_SETTLE;
      ST_STOP_SETTLE: state_d = ST_STOP_WAIT;
      ST_STOP_WAIT: begin
        if (!tx_stop_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wdog_hit) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end

    wdog_d = (waiting && (state_d == state_q)) ? wdog_q + 1'b1 : '0;
  end

  assign tx_byte         = tx_byte_q;
  assign tx_byte_trigger = (state_q == ST_PULSE);
  assign tx_stop_trigger = (state_q == ST_STOP_PULSE);
  assign tx_sel          = (state_q == ST_STOP_PULSE) || (state_q == ST_STOP_SETTLE) ||
                           (state_q == ST_STOP_WAIT);
  assign busy            = (state_q != ST_IDLE);
  assign cmd_dropped     = dropped_q;
  assign cmd_unsupported = unsup_q;
  assign tx_error        = WDOG_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_n64_response_sequencer.sv
// Directed bench for n64_response_sequencer with simple byte/stop transmitter
// models; the watchdog scenario adapts to N64_TX_WATCHDOG_EN.
module tb_n64_response_sequencer;

  localparam int TURN = 100;
  localparam int WDOG = 4096;
  localparam int BYTE_BUSY_CYCLES = 8;
  localparam int STOP_BUSY_CYCLES = 3;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic [15:0] buttons = 16'h0000;
  logic [7:0]  joy_x = 8'h00;
  logic [7:0]  joy_y = 8'h00;
  logic [7:0]  tx_byte;
  logic        tx_byte_trigger;
  logic        tx_stop_trigger;
  logic        tx_sel;
  logic        busy;
  logic        cmd_dropped;
  logic        cmd_unsupported;
  logic        tx_error;
  logic        byte_busy_model = 1'b0;
  logic        stop_busy_model = 1'b0;
  logic        hold_busy = 1'b0;
  logic        tx_byte_busy;
  logic        tx_stop_busy;

  assign tx_byte_busy = byte_busy_model | hold_busy;
  assign tx_stop_busy = stop_busy_model;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sent[$];
  int n_stop = 0, n_drop = 0, n_unsup = 0, n_err = 0, stop_sel_bad = 0;
  int first_trig = -1;
  int bcnt = 0, scnt = 0;
  int t0;

  n64_response_sequencer #(
    .TURNAROUND_CYCLES (TURN),
    .WDOG_CYCLES       (WDOG)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_byte        (cmd_byte),
    .buttons         (buttons),
    .joy_x           (joy_x),
    .joy_y           (joy_y),
    .tx_byte         (tx_byte),
    .tx_byte_trigger (tx_byte_trigger),
    .tx_byte_busy    (tx_byte_busy),
    .tx_stop_trigger (tx_stop_trigger),
    .tx_stop_busy    (tx_stop_busy),
    .tx_sel          (tx_sel),
    .busy            (busy),
    .cmd_dropped     (cmd_dropped),
    .cmd_unsupported (cmd_unsupported),
    .tx_error        (tx_error)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transmitter models and event monitor, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (bcnt > 0) begin
      bcnt = bcnt - 1;
      if (bcnt == 0) byte_busy_model = 1'b0;
    end
    if (scnt > 0) begin
      scnt = scnt - 1;
      if (scnt == 0) stop_busy_model = 1'b0;
    end
    if (tx_byte_trigger) begin
      sent.push_back(tx_byte);
      if (first_trig < 0) first_trig = cyc;
      bcnt = BYTE_BUSY_CYCLES;
      byte_busy_model = 1'b1;
    end
    if (tx_stop_trigger) begin
      n_stop = n_stop + 1;
      if (!tx_sel) stop_sel_bad = stop_sel_bad + 1;
      scnt = STOP_BUSY_CYCLES;
      stop_busy_model = 1'b1;
    end
    if (cmd_dropped) n_drop = n_drop + 1;
    if (cmd_unsupported) n_unsup = n_unsup + 1;
    if (tx_error) n_err = n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    sent.delete();
    n_stop = 0; n_drop = 0; n_unsup = 0; n_err = 0; stop_sel_bad = 0;
    first_trig = -1;
  endtask

  task automatic send_cmd(input logic [7:0] c, output int start);
    @(negedge sys_clk);
    cmd_byte  = c;
    cmd_valid = 1'b1;
    start     = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    repeat (12) @(negedge sys_clk);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < sent.size()) ? {24'd0, sent[i]} : 32'hDEAD, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] id_exp[$];
    logic [7:0] st_exp[$];
    int n;
    id_exp = '{8'h05, 8'h00, 8'h02};
    st_exp = '{8'hA5, 8'h5A, 8'h7F, 8'h81};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_outs", {tx_byte, tx_byte_trigger, tx_stop_trigger, tx_sel, cmd_dropped, cmd_unsupported, tx_error},
        32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Identity
    clear_log();
    send_cmd(8'h00, t0);
    chk("id_busy_turn", {31'd0, busy}, 1);
    wait_idle("id_idle", 2000);
    chk_bytes("id", id_exp);
    chk("id_latency", first_trig - t0, TURN + 2);
    chk("id_stop_count", n_stop, 1);
    chk("id_stop_sel", stop_sel_bad, 0);
    chk("id_sel_idle", {31'd0, tx_sel}, 0);
    chk("id_byte_hold", {24'd0, tx_byte}, 32'h02);

    // Status snapshot, inputs disturbed during TURN
    clear_log();
    buttons = 16'hA55A; joy_x = 8'h7F; joy_y = 8'h81;
    send_cmd(8'h01, t0);
    buttons = 16'h1234; joy_x = 8'h00; joy_y = 8'hFF;
    wait_idle("st_idle", 2000);
    chk_bytes("st", st_exp);
    chk("st_stop_count", n_stop, 1);

    // Overlap: status command during identity response is dropped
    clear_log();
    buttons = 16'hFFFF;
    send_cmd(8'hFF, t0);
    repeat (5) @(negedge sys_clk);
    send_cmd(8'h01, t0);
    wait_idle("ov_idle", 2000);
    repeat (20) @(negedge sys_clk);
    chk_bytes("ov", id_exp);
    chk("ov_dropped", n_drop, 1);
    chk("ov_stop_count", n_stop, 1);
    chk("ov_busy_after", {31'd0, busy}, 0);

    // Unknown command
    clear_log();
    send_cmd(8'h42, t0);
    repeat (5) @(negedge sys_clk);
    chk("unk_pulse", n_unsup, 1);
    chk("unk_busy", {31'd0, busy}, 0);
    chk("unk_triggers", sent.size() + n_stop, 0);

    // Simultaneous reset and command: reset wins
    clear_log();
    @(negedge sys_clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_byte = 8'h42;
    @(negedge sys_clk);
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rstcmd_unsup", {31'd0, cmd_unsupported}, 0);
    chk("rstcmd_busy", {31'd0, busy}, 0);

    // Reset while waiting on byte 2
    clear_log();
    send_cmd(8'h00, t0);
    n = 0;
    while (sent.size() < 2 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("mid_reached_b2", sent.size(), 2);
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_outs", {tx_byte, tx_byte_trigger, tx_stop_trigger, tx_sel}, 32'd0);
    repeat (15) @(negedge sys_clk);
    clear_log();
    send_cmd(8'h00, t0);
    wait_idle("mid_again_idle", 2000);
    chk_bytes("mid_again", id_exp);
    chk("mid_again_stop", n_stop, 1);

    // Watchdog
    clear_log();
    hold_busy = 1'b1;
    send_cmd(8'h00, t0);
`ifdef N64_TX_WATCHDOG_EN
    n = 0;
    while (n_err == 0 && n < TURN + WDOG + 50) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    chk("wd_error", n_err, 1);
    chk("wd_busy", {31'd0, busy}, 0);
    chk("wd_sel", {31'd0, tx_sel}, 0);
    hold_busy = 1'b0;
    repeat (15) @(negedge sys_clk);
`else
    repeat (TURN + WDOG + 50) @(negedge sys_clk);
    chk("nowd_busy", {31'd0, busy}, 1);
    chk("nowd_error", n_err, 0);
    chk("nowd_bytes", sent.size(), 1);
    hold_busy = 1'b0;
    wait_idle("nowd_release_idle", 2000);
    chk_bytes("nowd", id_exp);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
